// File: rtl/instr_encoder.sv
// instr_encoder: packs RV32 R/I/L/S fields into 32-bit words and writes them
// sequentially into an instruction memory with a per-word ack handshake.
module instr_encoder #(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [1:0]    fmt,
    input  logic [4:0]    rd,
    input  logic [4:0]    rs1,
    input  logic [4:0]    rs2,
    input  logic [2:0]    funct3,
    input  logic [6:0]    funct7,
    input  logic [31:0]   imm,
    input  logic          clear,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic          mem_ack,
    output logic [AW:0]   count,
    output logic          full,
    output logic          err
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] WRITE = 1'b1;

    localparam logic [1:0] FMT_R = 2'b00;
    localparam logic [1:0] FMT_I = 2'b01;
    localparam logic [1:0] FMT_L = 2'b10;
    localparam logic [1:0] FMT_S = 2'b11;

    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;
    localparam logic [6:0] OP_L = 7'b0000011;
    localparam logic [6:0] OP_S = 7'b0100011;

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [0:0]    state;
    logic [AW-1:0] ptr;
    logic [31:0]   enc;
    logic          imm_ok;
    logic          reject;
    logic          accept;

    assign full     = (count == FULL_CNT);
    assign in_ready = n_rst && (state == IDLE) && !full && !clear;
    assign accept   = in_valid && in_ready;

    // A 12-bit signed immediate means bits 31..11 are all copies of the sign.
    assign imm_ok = (imm[31:11] == '0) || (imm[31:11] == '1);
    assign reject = (fmt != FMT_R) && !imm_ok;

    always_comb begin
        enc = '0;
        unique case (fmt)
            FMT_R: enc = {funct7, rs2, rs1, funct3, rd, OP_R};
            FMT_I: enc = {imm[11:0], rs1, funct3, rd, OP_I};
            FMT_L: enc = {imm[11:0], rs1, funct3, rd, OP_L};
            FMT_S: enc = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_S};
            default: enc = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state     <= IDLE;
            ptr       <= '0;
            count     <= '0;
            err       <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (clear) begin
                        ptr   <= '0;
                        count <= '0;
                        err   <= 1'b0;
                    end else if (accept) begin
                        if (reject) begin
                            err <= 1'b1;
                        end else begin
                            mem_wdata <= enc;
                            mem_addr  <= ptr;
                            mem_we    <= 1'b1;
                            state     <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    // Outputs hold until the memory acknowledges the word.
                    if (mem_ack) begin
                        ptr    <= ptr + AW'(1);
                        mem_we <= 1'b0;
                        state  <= IDLE;
                        if (count != FULL_CNT) begin
                            count <= count + (AW+1)'(1);
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    mem_we <= 1'b0;
                end
            endcase
        end
    end

endmodule
